// File: rtl/id_decoder.sv
// Instruction-decode stage: decodes a fetched MIPS instruction into ALU controls,
// register addresses and memory/writeback controls, registered behind a valid/ready
// handshake. Stalls one cycle on a load-use dependency and drops state on a taken branch.
module id_decoder #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned IMM_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 d_i_clk,
  input  logic                 d_i_rst,
  input  logic [31:0]          d_i_instr,
  input  logic [PC_WIDTH-1:0]  d_i_pc,
  input  logic                 d_i_valid,
  output logic                 d_o_ready,
  input  logic                 d_i_ready,
  input  logic                 d_i_flush,
  output logic                 d_o_valid,
  output logic [4:0]           d_o_funct,
  output logic                 d_o_alu_src,
  output logic [IMM_WIDTH-1:0] d_o_imm,
  output logic [4:0]           d_o_rs_addr,
  output logic [4:0]           d_o_rt_addr,
  output logic [4:0]           d_o_rd_addr,
  output logic                 d_o_reg_write,
  output logic                 d_o_mem_read,
  output logic                 d_o_mem_write,
  output logic [PC_WIDTH-1:0]  d_o_pc,
  output logic                 d_o_illegal,
  output logic [CNT_WIDTH-1:0] d_o_illegal_cnt
);

  // ALU operation codes
  localparam logic [4:0] FnAdd  = 5'd0;
  localparam logic [4:0] FnSub  = 5'd1;
  localparam logic [4:0] FnAnd  = 5'd2;
  localparam logic [4:0] FnOr   = 5'd3;
  localparam logic [4:0] FnXor  = 5'd4;
  localparam logic [4:0] FnSlt  = 5'd5;
  localparam logic [4:0] FnSltu = 5'd6;
  localparam logic [4:0] FnSll  = 5'd7;
  localparam logic [4:0] FnSrl  = 5'd8;
  localparam logic [4:0] FnSra  = 5'd9;
  localparam logic [4:0] FnAddu = 5'd14;
  localparam logic [4:0] FnBeq  = 5'd15;
  localparam logic [4:0] FnBne  = 5'd16;

  // Raw instruction fields
  logic [5:0] op_f;
  logic [4:0] rs_f;
  logic [4:0] rt_f;
  logic [4:0] rd_f;
  logic [4:0] shamt_f;
  logic [5:0] fn_f;

  assign op_f    = d_i_instr[31:26];
  assign rs_f    = d_i_instr[25:21];
  assign rt_f    = d_i_instr[20:16];
  assign rd_f    = d_i_instr[15:11];
  assign shamt_f = d_i_instr[10:6];
  assign fn_f    = d_i_instr[5:0];

  // Decoded (pre-register) fields
  logic [4:0]  dec_funct;
  logic        dec_alu_src;
  logic [15:0] dec_imm;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_rd;
  logic        dec_writes;
  logic        dec_reg_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_illegal;
  logic        dec_uses_rt;

  // Combinational decode of the incoming instruction
  always_comb begin
    dec_funct     = FnAdd;
    dec_alu_src   = 1'b0;
    dec_imm       = 16'h0000;
    dec_rs        = rs_f;
    dec_rt        = rt_f;
    dec_rd        = 5'd0;
    dec_writes    = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_illegal   = 1'b0;
    dec_uses_rt   = 1'b0;

    unique case (op_f)
      6'h00: begin
        dec_uses_rt = 1'b1;
        dec_rd      = rd_f;
        dec_writes  = 1'b1;
        unique case (fn_f)
          6'h20: dec_funct = FnAdd;
          6'h21: dec_funct = FnAddu;
          6'h22: dec_funct = FnSub;
          6'h23: dec_funct = FnSub;
          6'h24: dec_funct = FnAnd;
          6'h25: dec_funct = FnOr;
          6'h26: dec_funct = FnXor;
          6'h2A: dec_funct = FnSlt;
          6'h2B: dec_funct = FnSltu;
          // Immediate shifts: the shifted value (rt) travels on operand 1
          6'h00, 6'h02, 6'h03: begin
            dec_funct   = (fn_f == 6'h00) ? FnSll : (fn_f == 6'h02) ? FnSrl : FnSra;
            dec_rs      = rt_f;
            dec_alu_src = 1'b1;
            dec_imm     = {11'b0, shamt_f};
          end
          // Variable shifts: value on operand 1, shift amount (rs) on operand 2
          6'h04, 6'h06, 6'h07: begin
            dec_funct = (fn_f == 6'h04) ? FnSll : (fn_f == 6'h06) ? FnSrl : FnSra;
            dec_rs    = rt_f;
            dec_rt    = rs_f;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
        unique case (op_f)
          6'h08:   dec_funct = FnAdd;
          6'h09:   dec_funct = FnAddu;
          6'h0A:   dec_funct = FnSlt;
          6'h0B:   dec_funct = FnSltu;
          6'h0C:   dec_funct = FnAnd;
          6'h0D:   dec_funct = FnOr;
          default: dec_funct = FnXor;
        endcase
        dec_alu_src = 1'b1;
        dec_imm     = d_i_instr[15:0];
        dec_rd      = rt_f;
        dec_writes  = 1'b1;
      end
      6'h23: begin
        dec_alu_src  = 1'b1;
        dec_imm      = d_i_instr[15:0];
        dec_rd       = rt_f;
        dec_writes   = 1'b1;
        dec_mem_read = 1'b1;
      end
      6'h2B: begin
        dec_uses_rt   = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm       = d_i_instr[15:0];
        dec_mem_write = 1'b1;
      end
      6'h04, 6'h05: begin
        dec_uses_rt = 1'b1;
        dec_funct   = (op_f == 6'h04) ? FnBeq : FnBne;
        dec_imm     = d_i_instr[15:0];
      end
      default: dec_illegal = 1'b1;
    endcase

    // Illegal instructions travel as an inert bubble with only the flag set
    if (dec_illegal) begin
      dec_funct     = FnAdd;
      dec_alu_src   = 1'b0;
      dec_imm       = 16'h0000;
      dec_rs        = 5'd0;
      dec_rt        = 5'd0;
      dec_rd        = 5'd0;
      dec_writes    = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
    end
  end

  // Writes to $0 are discarded, which also makes 0x00000000 a NOP
  assign dec_reg_write = dec_writes & (dec_rd != 5'd0);

  // Output registers
  logic                 valid_q;
  logic [4:0]           funct_q;
  logic                 alu_src_q;
  logic [IMM_WIDTH-1:0] imm_q;
  logic [4:0]           rs_q;
  logic [4:0]           rt_q;
  logic [4:0]           rd_q;
  logic                 reg_write_q;
  logic                 mem_read_q;
  logic                 mem_write_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic                 illegal_q;
  logic [CNT_WIDTH-1:0] illegal_cnt_q;

  logic hazard;
  logic accept;

  // Load-use check of the incoming instruction against the held load; raw fields are used
  // because the shift remapping does not change which registers are read
  always_comb begin
    hazard = valid_q & mem_read_q & (rd_q != 5'd0) &
             ((rs_f == rd_q) | (dec_uses_rt & (rt_f == rd_q)));
  end

  assign d_o_ready = (~valid_q | d_i_ready) & ~hazard;
  assign accept    = d_i_valid & d_o_ready & ~d_i_flush;

  // Pipeline register: load on accept, hold while stalled, empty when drained or flushed
  always_ff @(posedge d_i_clk) begin
    if (d_i_rst) begin
      valid_q       <= 1'b0;
      funct_q       <= '0;
      alu_src_q     <= 1'b0;
      imm_q         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      pc_q          <= '0;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= '0;
    end else if (d_i_flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q     <= 1'b1;
      funct_q     <= dec_funct;
      alu_src_q   <= dec_alu_src;
      imm_q       <= IMM_WIDTH'(dec_imm);
      rs_q        <= dec_rs;
      rt_q        <= dec_rt;
      rd_q        <= dec_rd;
      reg_write_q <= dec_reg_write;
      mem_read_q  <= dec_mem_read;
      mem_write_q <= dec_mem_write;
      pc_q        <= d_i_pc;
      illegal_q   <= dec_illegal;
      if (dec_illegal && (illegal_cnt_q != '1)) begin
        illegal_cnt_q <= illegal_cnt_q + CNT_WIDTH'(1);
      end
    end else if (d_i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign d_o_valid       = valid_q;
  assign d_o_funct       = funct_q;
  assign d_o_alu_src     = alu_src_q;
  assign d_o_imm         = imm_q;
  assign d_o_rs_addr     = rs_q;
  assign d_o_rt_addr     = rt_q;
  assign d_o_rd_addr     = rd_q;
  assign d_o_reg_write   = reg_write_q;
  assign d_o_mem_read    = mem_read_q;
  assign d_o_mem_write   = mem_write_q;
  assign d_o_pc          = pc_q;
  assign d_o_illegal     = illegal_q;
  assign d_o_illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_id_decoder.sv
// Bench for id_decoder: directed instructions with hand-decoded expectations queued on
// accept and compared by a monitor whenever execute takes an output.
module tb_id_decoder;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        in_valid;
  logic        out_ready_dut;
  logic        ex_ready;
  logic        flush;
  logic        out_valid;
  logic [4:0]  funct;
  logic        alu_src;
  logic [15:0] imm;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] out_pc;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  id_decoder #(
    .PC_WIDTH (32),
    .IMM_WIDTH(16),
    .CNT_WIDTH(8)
  ) dut (
    .d_i_clk        (clk),
    .d_i_rst        (rst),
    .d_i_instr      (instr),
    .d_i_pc         (pc),
    .d_i_valid      (in_valid),
    .d_o_ready      (out_ready_dut),
    .d_i_ready      (ex_ready),
    .d_i_flush      (flush),
    .d_o_valid      (out_valid),
    .d_o_funct      (funct),
    .d_o_alu_src    (alu_src),
    .d_o_imm        (imm),
    .d_o_rs_addr    (rs_addr),
    .d_o_rt_addr    (rt_addr),
    .d_o_rd_addr    (rd_addr),
    .d_o_reg_write  (reg_write),
    .d_o_mem_read   (mem_read),
    .d_o_mem_write  (mem_write),
    .d_o_pc         (out_pc),
    .d_o_illegal    (illegal),
    .d_o_illegal_cnt(illegal_cnt)
  );

  typedef struct packed {
    logic [4:0]  funct;
    logic        alu_src;
    logic [15:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] pc;
    logic        ill;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [4:0] f, input logic src, input logic [15:0] im,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic mw,
                              input logic [31:0] p, input logic ill, input logic [7:0] cnt);
    exp_t e;
    e = '{funct: f, alu_src: src, imm: im, rs: rs, rt: rt, rd: rd, rw: rw, mr: mr, mw: mw,
          pc: p, ill: ill, cnt: cnt};
    return e;
  endfunction

  // Monitor: every output transfer is checked against the oldest expectation
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (!rst && out_valid && ex_ready) begin
      act = '{funct: funct, alu_src: alu_src, imm: imm, rs: rs_addr, rt: rt_addr,
              rd: rd_addr, rw: reg_write, mr: mem_read, mw: mem_write, pc: out_pc,
              ill: illegal, cnt: illegal_cnt};
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output got=%h required=<none>", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL decode pc=%h got=%h required=%h", e.pc, act, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Offer one instruction, push its expectation at the accepting edge
  task automatic send(input logic [31:0] ins, input exp_t e);
    int waited;
    waited   = 0;
    instr    = ins;
    pc       = e.pc;
    in_valid = 1'b1;
    @(negedge clk);
    while (!out_ready_dut && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!out_ready_dut) begin
      check("accept_timeout", {31'b0, out_ready_dut}, 32'd1);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    instr    = 32'h0;
    pc       = 32'h0;
    in_valid = 1'b0;
    ex_ready = 1'b1;
    flush    = 1'b0;
    idle(2);
    @(negedge clk);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_funct", {27'b0, funct}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_cnt", {24'b0, illegal_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, out_ready_dut}, 32'd1);
    @(posedge clk);
    #1;

    // funct alu_src imm rs rt rd rw mr mw pc ill cnt
    send(32'h00221820, mk(5'd0, 1'b0, 16'h0000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0,
                          32'h100, 1'b0, 8'd0));
    send(32'h2085FFFF, mk(5'd0, 1'b1, 16'hFFFF, 5'd4, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0,
                          32'h104, 1'b0, 8'd0));
    send(32'h00031100, mk(5'd7, 1'b1, 16'h0004, 5'd3, 5'd3, 5'd2, 1'b1, 1'b0, 1'b0,
                          32'h108, 1'b0, 8'd0));
    send(32'h00A62022, mk(5'd1, 1'b0, 16'h0000, 5'd5, 5'd6, 5'd4, 1'b1, 1'b0, 1'b0,
                          32'h10C, 1'b0, 8'd0));
    send(32'h01283806, mk(5'd8, 1'b0, 16'h0000, 5'd8, 5'd9, 5'd7, 1'b1, 1'b0, 1'b0,
                          32'h110, 1'b0, 8'd0));
    send(32'hAC430004, mk(5'd0, 1'b1, 16'h0004, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1,
                          32'h114, 1'b0, 8'd0));
    send(32'h1420FFFE, mk(5'd16, 1'b0, 16'hFFFE, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                          32'h118, 1'b0, 8'd0));
    send(32'h342000FF, mk(5'd3, 1'b1, 16'h00FF, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                          32'h11C, 1'b0, 8'd0));
    send(32'h00000000, mk(5'd7, 1'b1, 16'h0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                          32'h120, 1'b0, 8'd0));
    send(32'h2D6A0005, mk(5'd6, 1'b1, 16'h0005, 5'd11, 5'd10, 5'd10, 1'b1, 1'b0, 1'b0,
                          32'h124, 1'b0, 8'd0));

    // Load-use: lw $1 followed by add $3,$1,$1
    send(32'h8C410000, mk(5'd0, 1'b1, 16'h0000, 5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0,
                          32'h200, 1'b0, 8'd0));
    instr    = 32'h00211820;
    pc       = 32'h204;
    in_valid = 1'b1;
    @(negedge clk);
    check("hazard_ready_low", {31'b0, out_ready_dut}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bubble_valid", {31'b0, out_valid}, 32'd0);
    check("bubble_ready", {31'b0, out_ready_dut}, 32'd1);
    sb.push_back(mk(5'd0, 1'b0, 16'h0000, 5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0,
                    32'h204, 1'b0, 8'd0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle(2);

    // beq held while execute stalls, then flushed
    ex_ready = 1'b0;
    send(32'h10220008, mk(5'd15, 1'b0, 16'h0008, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0,
                          32'h300, 1'b0, 8'd0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_funct", {27'b0, funct}, 32'd15);
      check("hold_imm", {16'b0, imm}, 32'h0008);
      check("hold_pc", out_pc, 32'h300);
      @(posedge clk);
      #1;
    end
    ex_ready = 1'b1;
    flush    = 1'b1;
    instr    = 32'h00221820;
    pc       = 32'h304;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_cnt", {24'b0, illegal_cnt}, 32'd0);
    @(posedge clk);
    #1;

    // Illegal stream: counter saturates at 0xFF
    for (int k = 1; k <= 300; k++) begin
      send(32'hFC000000, mk(5'd0, 1'b0, 16'h0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                            32'h1000 + 32'(k), 1'b1, (k > 255) ? 8'hFF : 8'(k)));
    end
    send(32'h0000003F, mk(5'd0, 1'b0, 16'h0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                          32'h2000, 1'b1, 8'hFF));

    begin
      int waited;
      waited = 0;
      while (sb.size() != 0 && waited < 20) begin
        waited++;
        @(posedge clk);
        #1;
      end
      check("queue_drained", 32'(sb.size()), 32'd0);
    end

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst2_cnt", {24'b0, illegal_cnt}, 32'd0);
    check("rst2_illegal", {31'b0, illegal}, 32'd0);
    check("rst2_valid", {31'b0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
